binary_mul_seq_param: RTL and testbench
=======================================

BINARY_MUL_SEQ_PARAM -- requirements
Module: binary_mul_seq_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 13, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter BPC, default 1, giving the multiplier bits retired per iteration (legal range 1..WIDTH).
REQ-003 The block SHALL define ITER = ceil(WIDTH/BPC), the number of compute iterations per operation.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 en  input  1  clock enable; when low, all state is frozen and no handshake completes.
REQ-007 in_valid  input  1  operands A, B and signed_mode are presented.
REQ-008 in_ready  output  1  block can accept operands this cycle.
REQ-009 A  input  WIDTH  multiplicand.
REQ-010 B  input  WIDTH  multiplier.
REQ-011 signed_mode  input  1  1 = two's-complement operands; 0 = unsigned operands; sampled at input handshake.
REQ-012 out_valid  output  1  P holds a completed product.
REQ-013 out_ready  input  1  downstream accepts P.
REQ-014 P  output  2*WIDTH  product.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-016 An input handshake SHALL occur on a rising edge where en=1, in_valid=1 and in_ready=1; A, B and signed_mode SHALL be captured only on that edge.
REQ-017 in_ready SHALL be combinational: en AND (state==IDLE OR (state==DONE AND out_ready)).
REQ-018 On an input handshake the FSM SHALL enter CALC, with the iteration counter cleared and the accumulator zeroed.
REQ-019 In CALC, each edge with en=1 SHALL add the partial product of A and the next BPC-bit group of B (LSB group first), suitably shifted, into the accumulator, then increment the counter.
REQ-020 For a final group narrower than BPC (WIDTH not divisible by BPC), only the valid bits SHALL contribute.
REQ-021 In signed mode, A SHALL be sign-extended to 2*WIDTH, and the MSB of B SHALL carry negative weight; this SHALL be implemented by subtracting the final group's MSB term rather than adding it.
REQ-022 In unsigned mode, both operands SHALL be zero-extended.
REQ-023 After the ITER-th CALC edge with en=1, the FSM SHALL enter DONE, and out_valid SHALL be registered high from the next cycle onward.
REQ-024 Latency SHALL be ITER+1 enabled edges from the input-handshake edge to the first cycle with out_valid=1; with WIDTH=13 and BPC=1 this is 14.
REQ-025 P SHALL equal the exact product modulo 2^(2*WIDTH); in signed mode, P SHALL be the sign-extended two's-complement product.
REQ-026 P and out_valid SHALL be held stable in DONE while out_ready=0 or en=0 (backpressure).
REQ-027 An output handshake on an edge with en=1, out_valid=1 and out_ready=1 SHALL return the FSM to IDLE and clear out_valid, unless a simultaneous input handshake occurs.
REQ-028 On a simultaneous output and input handshake in DONE, the FSM SHALL go directly to CALC with the new operands; out_valid SHALL fall on that same edge (back-to-back throughput of one result per ITER+1 cycles).
REQ-029 Any edge with en=0 SHALL freeze the FSM, counter, accumulator, P and out_valid, and SHALL stretch the latency by the number of such edges.
REQ-030 in_valid asserted outside IDLE or DONE-with-out_ready SHALL be ignored, with no side effect.
REQ-031 When in the zero-operand case (A=0 or B=0), the block SHALL still take the full ITER+1 latency; there is no early termination.

Reset
REQ-032 On an edge with rst_n=0 the block SHALL enter IDLE and SHALL set out_valid=0, P=0, counter=0 and accumulator=0, regardless of en.
REQ-033 Reset asserted during CALC or DONE SHALL abort the operation; no out_valid SHALL be produced for the aborted operands.
REQ-034 in_ready SHALL be 0 on any cycle where rst_n=0.

Verification
REQ-035 WIDTH=13, BPC=1, signed, A=-4096, B=-4096, out_ready=1 -> out_valid rises exactly 14 edges after the handshake, with P=16777216.
REQ-036 WIDTH=13, BPC=1, unsigned, A=8191, B=8191 -> P=67092481 after 14 edges; then signed with the same bit patterns (A=-1, B=-1) -> P=1.
REQ-037 WIDTH=13, BPC=4 (ITER=4), signed, A=-4096, B=4095 -> out_valid after 5 edges, with P=-16773120 (26-bit two's complement).
REQ-038 Backpressure and back-to-back: hold out_ready=0 for 5 cycles after out_valid -> P is stable; then assert out_ready and in_valid together with A=3, B=-5 signed -> new handshake on the same edge, and P=-15 appears 14 edges later.
REQ-039 en=0 for 3 edges mid-CALC -> latency becomes 17 with a correct product; rst_n=0 for one edge mid-CALC -> out_valid stays 0, P=0, in_ready returns to 1 on the next cycle.
REQ-040 Exhaustive sweep of WIDTH=6 for BPC in {1, 2, 4, 6} across both modes -> every P matches the reference product.

Source files
------------

// File: rtl/binary_mul_seq_param_if.sv
// Operand/product handshake bundle for the sequential multiplier.
// The master side presents operands and drains products; the slave is the multiplier.
interface binary_mul_seq_param_if #(
    parameter int WIDTH = 13
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   P;

    modport master (
        output in_valid, A, B, signed_mode, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, A, B, signed_mode, out_ready,
        output in_ready, out_valid, P
    );
endinterface

// File: rtl/binary_mul_seq_param.sv
// Sequential shift-add multiplier retiring BPC multiplier bits per enabled cycle,
// unsigned or two's-complement, with valid/ready handshakes on both sides.
//
//   state | meaning
//   IDLE  | waiting for operands
//   CALC  | accumulating one BPC-bit group of B per enabled edge
//   DONE  | product held in P with out_valid high until drained
module binary_mul_seq_param #(
    parameter int WIDTH = 13,
    parameter int BPC   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    binary_mul_seq_param_if.slave  bus
);
    localparam int ITER     = (WIDTH + BPC - 1) / BPC;
    localparam int CW       = $clog2(ITER + 1);
    localparam int PW       = 2 * WIDTH;
    localparam int LAST_POS = WIDTH - 1 - (ITER - 1) * BPC;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     a_q, a_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     p_q, p_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sgn_q, sgn_d;
    logic              out_valid_q, out_valid_d;

    logic              in_ready;
    logic              in_hs;
    logic              out_hs;
    logic              last;
    logic [BPC-1:0]    grp;
    logic [BPC-1:0]    grp_lo;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     msb_term;
    logic [PW-1:0]     acc_next;

    assign in_ready = rst_n & en & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
    assign in_hs    = in_ready & bus.in_valid;
    assign out_hs   = en & out_valid_q & bus.out_ready;
    assign last     = (cnt_q == CW'(ITER - 1));

    // a_q is pre-shifted each step, so the group product lands at the right weight.
    // In signed mode B's MSB is removed from the group and subtracted instead.
    always_comb begin
        grp    = b_q[BPC-1:0];
        grp_lo = grp;
        if (sgn_q && last) begin
            grp_lo[LAST_POS] = 1'b0;
        end
        pp       = a_q * PW'(grp_lo);
        msb_term = (sgn_q && last && grp[LAST_POS]) ? (a_q << LAST_POS) : '0;
        acc_next = acc_q + pp - msb_term;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        p_d         = p_q;
        sgn_d       = sgn_q;
        out_valid_d = out_valid_q;
        if (en) begin
            case (state_q)
                IDLE: ;
                CALC: begin
                    acc_d = acc_next;
                    a_d   = a_q << BPC;
                    b_d   = b_q >> BPC;
                    cnt_d = cnt_q + CW'(1);
                    if (last) begin
                        state_d     = DONE;
                        p_d         = acc_next;
                        out_valid_d = 1'b1;
                    end
                end
                DONE: begin
                    if (out_hs) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (in_hs) begin
                state_d     = CALC;
                cnt_d       = '0;
                acc_d       = '0;
                a_d         = {{WIDTH{bus.signed_mode & bus.A[WIDTH-1]}}, bus.A};
                b_d         = bus.B;
                sgn_d       = bus.signed_mode;
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            sgn_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            sgn_q       <= sgn_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.P         = p_q;
endmodule

// File: tb/tb_binary_mul_seq_param.sv
// Directed bench for binary_mul_seq_param: WIDTH=13 (BPC 1 and 4) vectors and corner
// sequences, plus an exhaustive WIDTH=6 sweep over four BPC settings.
module tb_binary_mul_seq_param;
    logic clk;
    logic rst_n;
    logic en;

    int n_chk;
    int n_fail;

    binary_mul_seq_param_if #(.WIDTH(13)) i1 ();
    binary_mul_seq_param_if #(.WIDTH(13)) i4 ();
    binary_mul_seq_param_if #(.WIDTH(6))  w1 ();
    binary_mul_seq_param_if #(.WIDTH(6))  w2 ();
    binary_mul_seq_param_if #(.WIDTH(6))  w4 ();
    binary_mul_seq_param_if #(.WIDTH(6))  w6 ();

    binary_mul_seq_param #(.WIDTH(13), .BPC(1)) u_13_1 (.clk(clk), .rst_n(rst_n), .en(en), .bus(i1));
    binary_mul_seq_param #(.WIDTH(13), .BPC(4)) u_13_4 (.clk(clk), .rst_n(rst_n), .en(en), .bus(i4));
    binary_mul_seq_param #(.WIDTH(6),  .BPC(1)) u_6_1  (.clk(clk), .rst_n(rst_n), .en(en), .bus(w1));
    binary_mul_seq_param #(.WIDTH(6),  .BPC(2)) u_6_2  (.clk(clk), .rst_n(rst_n), .en(en), .bus(w2));
    binary_mul_seq_param #(.WIDTH(6),  .BPC(4)) u_6_4  (.clk(clk), .rst_n(rst_n), .en(en), .bus(w4));
    binary_mul_seq_param #(.WIDTH(6),  .BPC(6)) u_6_6  (.clk(clk), .rst_n(rst_n), .en(en), .bus(w6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel4;
        bit          sgn;
        logic [12:0] a;
        logic [12:0] b;
        logic [25:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic get_ov(input bit sel4);
        return sel4 ? i4.out_valid : i1.out_valid;
    endfunction

    function automatic logic get_ir(input bit sel4);
        return sel4 ? i4.in_ready : i1.in_ready;
    endfunction

    function automatic logic [25:0] get_p(input bit sel4);
        return sel4 ? i4.P : i1.P;
    endfunction

    task automatic drive13(input bit sel4, input logic iv, input logic [12:0] a,
                           input logic [12:0] b, input logic s, input logic orr);
        if (sel4) begin
            i4.in_valid = iv; i4.A = a; i4.B = b; i4.signed_mode = s; i4.out_ready = orr;
        end else begin
            i1.in_valid = iv; i1.A = a; i1.B = b; i1.signed_mode = s; i1.out_ready = orr;
        end
    endtask

    task automatic set6(input logic iv, input logic [5:0] a, input logic [5:0] b,
                        input logic s, input logic orr);
        w1.in_valid = iv; w1.A = a; w1.B = b; w1.signed_mode = s; w1.out_ready = orr;
        w2.in_valid = iv; w2.A = a; w2.B = b; w2.signed_mode = s; w2.out_ready = orr;
        w4.in_valid = iv; w4.A = a; w4.B = b; w4.signed_mode = s; w4.out_ready = orr;
        w6.in_valid = iv; w6.A = a; w6.B = b; w6.signed_mode = s; w6.out_ready = orr;
    endtask

    // Waits for out_valid; the handshake edge counts as edge 1.
    task automatic wait_ov(input bit sel4, inout int lat);
        while (!get_ov(sel4) && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string name, input vec_t v);
        int lat;
        drive13(v.sel4, 1'b1, v.a, v.b, v.sgn, 1'b0);
        chk({name, "_in_ready"}, 64'(get_ir(v.sel4)), 64'd1);
        tick();
        drive13(v.sel4, 1'b0, v.a, v.b, v.sgn, 1'b0);
        lat = 1;
        wait_ov(v.sel4, lat);
        chk({name, "_latency"}, 64'(lat), 64'(v.lat));
        chk({name, "_P"}, 64'(get_p(v.sel4)), 64'(v.p));
        drive13(v.sel4, 1'b0, v.a, v.b, v.sgn, 1'b1);
        tick();
        drive13(v.sel4, 1'b0, v.a, v.b, v.sgn, 1'b0);
        chk({name, "_ov_cleared"}, 64'(get_ov(v.sel4)), 64'd0);
    endtask

    initial begin
        int lat;
        bit stable;
        bit seen;
        bit all_ov;
        int k;
        logic signed [5:0]  sa;
        logic signed [5:0]  sb;
        logic signed [11:0] sp;
        logic [11:0]        ref_p;

        n_chk  = 0;
        n_fail = 0;

        vecs[0]  = '{1'b0, 1'b1, 13'h1000, 13'h1000, 26'd16777216, 14};
        vecs[1]  = '{1'b0, 1'b0, 13'h1FFF, 13'h1FFF, 26'd67092481, 14};
        vecs[2]  = '{1'b0, 1'b1, 13'h1FFF, 13'h1FFF, 26'd1,        14};
        vecs[3]  = '{1'b0, 1'b1, 13'd3,    13'h1FFB, 26'd67108849, 14};
        vecs[4]  = '{1'b0, 1'b0, 13'd0,    13'd1234, 26'd0,        14};
        vecs[5]  = '{1'b0, 1'b0, 13'd100,  13'd200,  26'd20000,    14};
        vecs[6]  = '{1'b0, 1'b1, 13'h1FFF, 13'h0FFF, 26'd67104769, 14};
        vecs[7]  = '{1'b0, 1'b1, 13'h1000, 13'd1,    26'd67104768, 14};
        vecs[8]  = '{1'b0, 1'b1, 13'd1,    13'h1000, 26'd67104768, 14};
        vecs[9]  = '{1'b1, 1'b1, 13'h1000, 13'h0FFF, 26'd50335744, 5};
        vecs[10] = '{1'b1, 1'b0, 13'h1FFF, 13'h1FFF, 26'd67092481, 5};
        vecs[11] = '{1'b1, 1'b1, 13'h1FFF, 13'h1FFF, 26'd1,        5};
        vecs[12] = '{1'b1, 1'b1, 13'd3,    13'h1FFB, 26'd67108849, 5};

        rst_n = 1'b0;
        en    = 1'b1;
        drive13(1'b0, 1'b0, 13'd0, 13'd0, 1'b0, 1'b0);
        drive13(1'b1, 1'b0, 13'd0, 13'd0, 1'b0, 1'b0);
        set6(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_in_ready_low", 64'(i1.in_ready), 64'd0);
        chk("rst_ov", 64'(i1.out_valid), 64'd0);
        chk("rst_P", 64'(i1.P), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(i1.in_ready), 64'd1);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // backpressure then back-to-back handshake
        drive13(1'b0, 1'b1, 13'd5, 13'd7, 1'b0, 1'b0);
        tick();
        drive13(1'b0, 1'b0, 13'd5, 13'd7, 1'b0, 1'b0);
        lat = 1;
        wait_ov(1'b0, lat);
        chk("bp_latency", 64'(lat), 64'd14);
        chk("bp_in_ready_blocked", 64'(i1.in_ready), 64'd0);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i1.P !== 26'd35 || i1.out_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp_P_stable", 64'(stable), 64'd1);
        drive13(1'b0, 1'b1, 13'd3, 13'h1FFB, 1'b1, 1'b1);
        #1;
        chk("b2b_in_ready", 64'(i1.in_ready), 64'd1);
        tick();
        drive13(1'b0, 1'b0, 13'd3, 13'h1FFB, 1'b1, 1'b0);
        chk("b2b_ov_fell", 64'(i1.out_valid), 64'd0);
        lat = 1;
        wait_ov(1'b0, lat);
        chk("b2b_latency", 64'(lat), 64'd14);
        chk("b2b_P", 64'(i1.P), 64'd67108849);
        drive13(1'b0, 1'b0, 13'd0, 13'd0, 1'b0, 1'b1);
        tick();
        drive13(1'b0, 1'b0, 13'd0, 13'd0, 1'b0, 1'b0);

        // enable stall plus ignored in_valid during CALC
        drive13(1'b0, 1'b1, 13'd100, 13'd200, 1'b0, 1'b0);
        tick();
        drive13(1'b0, 1'b0, 13'd100, 13'd200, 1'b0, 1'b0);
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            lat++;
        end
        drive13(1'b0, 1'b1, 13'd1, 13'd1, 1'b1, 1'b0);
        chk("calc_in_ready_low", 64'(i1.in_ready), 64'd0);
        tick();
        lat++;
        drive13(1'b0, 1'b0, 13'd1, 13'd1, 1'b1, 1'b0);
        en = 1'b0;
        #1;
        chk("en_low_in_ready", 64'(i1.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            lat++;
        end
        en = 1'b1;
        wait_ov(1'b0, lat);
        chk("stall_latency", 64'(lat), 64'd17);
        chk("stall_P", 64'(i1.P), 64'd20000);
        drive13(1'b0, 1'b0, 13'd0, 13'd0, 1'b0, 1'b1);
        tick();
        drive13(1'b0, 1'b0, 13'd0, 13'd0, 1'b0, 1'b0);

        // reset mid-CALC aborts the operation
        drive13(1'b0, 1'b1, 13'd7, 13'd9, 1'b0, 1'b1);
        tick();
        drive13(1'b0, 1'b0, 13'd7, 13'd9, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_ov", 64'(i1.out_valid), 64'd0);
        chk("abort_P", 64'(i1.P), 64'd0);
        chk("abort_in_ready_in_rst", 64'(i1.in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 64'(i1.in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i1.out_valid) seen = 1'b1;
        end
        chk("abort_no_ov", 64'(seen), 64'd0);
        drive13(1'b0, 1'b0, 13'd0, 13'd0, 1'b0, 1'b0);

        // exhaustive WIDTH=6 sweep, all four BPC variants in lockstep
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 64; a++) begin
                for (int b = 0; b < 64; b++) begin
                    set6(1'b1, 6'(a), 6'(b), m[0], 1'b1);
                    tick();
                    set6(1'b0, 6'(a), 6'(b), m[0], 1'b0);
                    k = 0;
                    all_ov = w1.out_valid & w2.out_valid & w4.out_valid & w6.out_valid;
                    while (!all_ov && k < 12) begin
                        tick();
                        k++;
                        all_ov = w1.out_valid & w2.out_valid & w4.out_valid & w6.out_valid;
                    end
                    if (!all_ov) chk("sweep_timeout", 64'(all_ov), 64'd1);
                    if (m == 1) begin
                        sa = 6'(a);
                        sb = 6'(b);
                        sp = sa * sb;
                        ref_p = sp;
                    end else begin
                        ref_p = 12'(a * b);
                    end
                    chk($sformatf("sw_b1_m%0d_%0d_%0d", m, a, b), 64'(w1.P), 64'(ref_p));
                    chk($sformatf("sw_b2_m%0d_%0d_%0d", m, a, b), 64'(w2.P), 64'(ref_p));
                    chk($sformatf("sw_b4_m%0d_%0d_%0d", m, a, b), 64'(w4.P), 64'(ref_p));
                    chk($sformatf("sw_b6_m%0d_%0d_%0d", m, a, b), 64'(w6.P), 64'(ref_p));
                end
            end
        end
        set6(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
        tick();
        set6(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
        chk("sweep_drained", 64'(w1.out_valid | w6.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
